// File: rtl/envgen_pkg.sv
// Shared types and saturating helpers for the polyphonic ADSR envelope generator.
package envgen_pkg;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_ATTACK  = 5'b00010,
    ST_DECAY   = 5'b00100,
    ST_SUSTAIN = 5'b01000,
    ST_RELEASE = 5'b10000
  } env_state_e;

  // Helpers work at 32 bits; callers narrow the result back to the level width.
  localparam int unsigned ENV_HELPER_W = 32;

  function automatic logic [ENV_HELPER_W-1:0] env_min(input logic [ENV_HELPER_W-1:0] a,
                                                       input logic [ENV_HELPER_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [ENV_HELPER_W-1:0] env_max(input logic [ENV_HELPER_W-1:0] a,
                                                       input logic [ENV_HELPER_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/envgen_voice.sv
// One ADSR voice: one-hot FSM plus level register, advanced on the sample tick.
// ENVGEN_EXP_RELEASE_EN selects exponential instead of linear release.
module envgen_voice
  import envgen_pkg::*;
#(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         i_rst_b,
  input  logic         i_tick,
  input  logic         i_note_on,
  input  logic         i_note_off,
  input  logic [W-1:0] i_atk_rate,
  input  logic [W-1:0] i_dec_rate,
  input  logic [W-1:0] i_rel_rate,
  input  logic [W-1:0] i_peak_lvl,
  input  logic [W-1:0] i_sus_lvl,
  output logic [W-1:0] o_level,
  output logic         o_busy,
  output logic         o_done
);

  localparam logic [W-1:0] LVL_ZERO = {W{1'b0}};
  localparam logic [W-1:0] LVL_ONE  = {{(W-1){1'b0}}, 1'b1};

  env_state_e   r_state;
  env_state_e   w_state_nxt;
  logic [W-1:0] r_level;
  logic [W-1:0] w_lvl_nxt;
  logic         r_done;
  logic         w_done_nxt;

  logic [W-1:0] w_st;
  logic [W:0]   w_atk_sum;
  logic         w_atk_hit;
  logic [W-1:0] w_dec_sub;
  logic [W-1:0] w_dec_lvl;
  logic [W-1:0] w_rel_step;
  logic [W-1:0] w_rel_lvl;

  assign w_st      = W'(env_min(ENV_HELPER_W'(i_sus_lvl), ENV_HELPER_W'(i_peak_lvl)));
  assign w_atk_sum = {1'b0, r_level} + {1'b0, i_atk_rate};
  // Zero rate jumps straight to peak; a level already above peak clamps down.
  assign w_atk_hit = (i_atk_rate == LVL_ZERO) || (w_atk_sum >= {1'b0, i_peak_lvl});
  assign w_dec_sub = (r_level > i_dec_rate) ? (r_level - i_dec_rate) : LVL_ZERO;
  assign w_dec_lvl = (i_dec_rate == LVL_ZERO) ? w_st
                   : W'(env_max(ENV_HELPER_W'(w_dec_sub), ENV_HELPER_W'(w_st)));

`ifdef ENVGEN_EXP_RELEASE_EN
  assign w_rel_step = (r_level >> i_rel_rate[4:0]) | LVL_ONE;
`else
  assign w_rel_step = i_rel_rate;
`endif
  assign w_rel_lvl = ((i_rel_rate == LVL_ZERO) || (r_level <= w_rel_step)) ? LVL_ZERO
                   : (r_level - w_rel_step);

  // Next-state, next-level and done-pulse decode; requests take priority over ramps.
  always_comb begin
    w_state_nxt = r_state;
    w_lvl_nxt   = r_level;
    w_done_nxt  = 1'b0;
    if (r_state == ST_IDLE) begin
      w_lvl_nxt = LVL_ZERO;
      if (i_note_on) begin
        w_state_nxt = ST_ATTACK;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end else if (i_note_on) begin
      w_state_nxt = ST_ATTACK;
    end else if (i_note_off && (r_state != ST_RELEASE)) begin
      w_state_nxt = ST_RELEASE;
    end else begin
      case (r_state)
        ST_ATTACK: begin
          if (i_tick && w_atk_hit) begin
            w_lvl_nxt   = i_peak_lvl;
            w_state_nxt = ST_DECAY;
          end else if (i_tick) begin
            w_lvl_nxt = w_atk_sum[W-1:0];
          end else begin
            w_lvl_nxt = r_level;
          end
        end
        ST_DECAY: begin
          if (i_tick) begin
            w_lvl_nxt = w_dec_lvl;
            if (w_dec_lvl == w_st) begin
              w_state_nxt = ST_SUSTAIN;
            end else begin
              w_state_nxt = ST_DECAY;
            end
          end else begin
            w_lvl_nxt = r_level;
          end
        end
        ST_SUSTAIN: begin
          w_lvl_nxt = w_st;
        end
        ST_RELEASE: begin
          if (i_tick) begin
            w_lvl_nxt = w_rel_lvl;
            if (w_rel_lvl == LVL_ZERO) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_RELEASE;
            end
          end else begin
            w_lvl_nxt = r_level;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_lvl_nxt   = LVL_ZERO;
        end
      endcase
    end
  end

  // State, level and done registers.
  always_ff @(posedge clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_state <= ST_IDLE;
      r_level <= LVL_ZERO;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_lvl_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_level = r_level;
  assign o_busy  = (r_state != ST_IDLE);
  assign o_done  = r_done;

endmodule

// File: rtl/envgen_poly.sv
// Polyphonic ADSR envelope generator: VOICES independent envgen_voice instances sharing one shape.
// ENVGEN_EXP_RELEASE_EN selects exponential release in every voice.
module envgen_poly
  import envgen_pkg::*;
#(
  parameter int VOICES = 8,
  parameter int W      = 18
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                tick,
  input  logic [VOICES-1:0]   note_on,
  input  logic [VOICES-1:0]   note_off,
  input  logic [W-1:0]        atk_rate,
  input  logic [W-1:0]        dec_rate,
  input  logic [W-1:0]        rel_rate,
  input  logic [W-1:0]        peak_lvl,
  input  logic [W-1:0]        sus_lvl,
  output logic [VOICES*W-1:0] level,
  output logic [VOICES-1:0]   busy,
  output logic [VOICES-1:0]   done
);

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    envgen_voice #(.W(W)) u_voice (
      .clk        (clk),
      .i_rst_b    (rst_b),
      .i_tick     (tick),
      .i_note_on  (note_on[v]),
      .i_note_off (note_off[v]),
      .i_atk_rate (atk_rate),
      .i_dec_rate (dec_rate),
      .i_rel_rate (rel_rate),
      .i_peak_lvl (peak_lvl),
      .i_sus_lvl  (sus_lvl),
      .o_level    (level[v*W +: W]),
      .o_busy     (busy[v]),
      .o_done     (done[v])
    );
  end

endmodule

// File: tb/tb_envgen_poly.sv
// Scoreboard bench for envgen_poly; expected per-voice outputs are queued at stimulus time.
module tb_envgen_poly;
  localparam int VOICES = 8;
  localparam int W      = 18;
`ifdef ENVGEN_EXP_RELEASE_EN
  localparam int RETRIG_REL = 2;
  localparam int TAIL_REL   = 4;
`else
  localparam int RETRIG_REL = 'h800;
  localparam int TAIL_REL   = 'h1000;
`endif

  logic                clk = 1'b0;
  logic                rst_b = 1'b0;
  logic                tick = 1'b0;
  logic [VOICES-1:0]   note_on = '0;
  logic [VOICES-1:0]   note_off = '0;
  logic [W-1:0]        atk_rate = '0, dec_rate = '0, rel_rate = '0, peak_lvl = '0, sus_lvl = '0;
  logic [VOICES*W-1:0] level;
  logic [VOICES-1:0]   busy, done;

  envgen_poly #(.VOICES(VOICES), .W(W)) dut (
    .clk(clk), .rst_b(rst_b), .tick(tick), .note_on(note_on), .note_off(note_off),
    .atk_rate(atk_rate), .dec_rate(dec_rate), .rel_rate(rel_rate),
    .peak_lvl(peak_lvl), .sus_lvl(sus_lvl), .level(level), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    int           v;
    logic [W-1:0] lvl;
    logic         bsy;
    logic         dn;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic expect_v(input int v, input int lvl, input logic b, input logic d);
    exp_t e;
    e.cyc = cyc + 1;
    e.v   = v;
    e.lvl = W'(lvl);
    e.bsy = b;
    e.dn  = d;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rel_next(input int lvl, input int rate);
    int s;
`ifdef ENVGEN_EXP_RELEASE_EN
    s = (lvl >> (rate & 31)) | 1;
`else
    s = rate;
`endif
    if (rate == 0 || lvl <= s) return 0;
    return lvl - s;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc != cyc) check_eq("sb_stale", e.cyc, cyc);
      check_eq($sformatf("v%0d_level", e.v), 32'(level[e.v*W +: W]), 32'(e.lvl));
      check_eq($sformatf("v%0d_busy", e.v), 32'(busy[e.v]), 32'(e.bsy));
      check_eq($sformatf("v%0d_done", e.v), 32'(done[e.v]), 32'(e.dn));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lvl;
    int n;
    tick = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int v = 0; v < VOICES; v++) check_eq("rst_level", 32'(level[v*W +: W]), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    rst_b = 1'b1;
    atk_rate = 18'h01000; peak_lvl = 18'h3FFFF; dec_rate = 18'h00800;
    sus_lvl  = 18'h20000; rel_rate = 18'h00800;
    step();

    // Attack, decay, sustain on voice 0
    note_on = 8'h01; expect_v(0, 0, 1, 0); expect_v(1, 0, 0, 0); step(); note_on = '0;
    for (int k = 1; k <= 64; k++) begin
      lvl = k * 'h1000;
      if (lvl > 'h3FFFF) lvl = 'h3FFFF;
      expect_v(0, lvl, 1, 0); step();
    end
    for (int j = 1; j <= 64; j++) begin
      lvl = 'h3FFFF - j * 'h800;
      if (lvl < 'h20000) lvl = 'h20000;
      expect_v(0, lvl, 1, 0); step();
    end
    repeat (3) begin expect_v(0, 'h20000, 1, 0); expect_v(1, 0, 0, 0); step(); end

    // Release to idle with done pulse
    note_off = 8'h01; expect_v(0, 'h20000, 1, 0); step(); note_off = '0;
    lvl = 'h20000;
    for (int i = 0; i < 200 && lvl != 0; i++) begin
      lvl = rel_next(lvl, 'h800); expect_v(0, lvl, lvl != 0, lvl == 0); step();
    end
    expect_v(0, 0, 0, 0); step();

    // Legato retrigger mid-release, then simultaneous on+off in sustain
    atk_rate = '0; dec_rate = '0; rel_rate = W'(RETRIG_REL);
    note_on = 8'h01; expect_v(0, 0, 1, 0); step(); note_on = '0;
    expect_v(0, 'h3FFFF, 1, 0); step();
    expect_v(0, 'h20000, 1, 0); step();
    note_off = 8'h01; expect_v(0, 'h20000, 1, 0); step(); note_off = '0;
    lvl = 'h20000;
    while (lvl > 'h15000) begin
      lvl = rel_next(lvl, RETRIG_REL); expect_v(0, lvl, lvl != 0, lvl == 0); step();
    end
    atk_rate = 18'h01000;
    note_on = 8'h01; expect_v(0, lvl, 1, 0); step(); note_on = '0;
    for (int k = 1; k <= 4; k++) begin expect_v(0, lvl + k * 'h1000, 1, 0); step(); end
    atk_rate = '0;
    expect_v(0, 'h3FFFF, 1, 0); step();
    expect_v(0, 'h20000, 1, 0); step();
    note_on = 8'h01; note_off = 8'h01; expect_v(0, 'h20000, 1, 0); step();
    note_on = '0; note_off = '0;
    expect_v(0, 'h3FFFF, 1, 0); step();
    expect_v(0, 'h20000, 1, 0); step();

    // Zero release rate: instant drop to idle
    rel_rate = '0;
    note_off = 8'h01; expect_v(0, 'h20000, 1, 0); step(); note_off = '0;
    expect_v(0, 0, 0, 1); step();
    expect_v(0, 0, 0, 0); step();

    // Zero rates with sus above peak, then live sustain edit without tick
    peak_lvl = 18'h10000; sus_lvl = 18'h30000;
    note_on = 8'h01; expect_v(0, 0, 1, 0); step(); note_on = '0;
    expect_v(0, 'h10000, 1, 0); step();
    expect_v(0, 'h10000, 1, 0); step();
    tick = 1'b0; sus_lvl = 18'h08000; expect_v(0, 'h08000, 1, 0); step();
    expect_v(0, 'h08000, 1, 0); step();
    tick = 1'b1;

    // Several voices running; voice 3 stimulus leaves others alone
    peak_lvl = 18'h3FFFF; sus_lvl = 18'h20000; atk_rate = 18'h01000;
    dec_rate = 18'h00800; rel_rate = 18'h00800;
    note_on = 8'h06; expect_v(0, 'h20000, 1, 0); expect_v(1, 0, 1, 0); expect_v(2, 0, 1, 0);
    step(); note_on = '0;
    for (int k = 1; k <= 3; k++) begin
      expect_v(0, 'h20000, 1, 0); expect_v(1, k * 'h1000, 1, 0); expect_v(2, k * 'h1000, 1, 0);
      step();
    end
    note_on = 8'h08; note_off = 8'h10;
    expect_v(3, 0, 1, 0); expect_v(4, 0, 0, 0); expect_v(1, 'h4000, 1, 0); expect_v(2, 'h4000, 1, 0);
    step(); note_on = '0; note_off = '0;
    for (int k = 1; k <= 2; k++) begin
      expect_v(3, k * 'h1000, 1, 0); expect_v(1, (4 + k) * 'h1000, 1, 0);
      expect_v(2, (4 + k) * 'h1000, 1, 0); expect_v(0, 'h20000, 1, 0);
      step();
    end

    // Asynchronous reset mid-attack aborts everything with no done
    @(negedge clk); #1;
    check_eq("sb_empty_pre_reset", sb.size(), 0);
    rst_b = 1'b0; #1;
    for (int v = 0; v < VOICES; v++) check_eq("arst_level", 32'(level[v*W +: W]), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check_eq("arst_hold_done", 32'(done), 32'd0);
      check_eq("arst_hold_busy", 32'(busy), 32'd0);
    end
    @(posedge clk); #1; rst_b = 1'b1;
    for (int v = 0; v < 4; v++) expect_v(v, 0, 0, 0);
    step();

    // Long release tail from full scale
    peak_lvl = 18'h3FFFF; sus_lvl = 18'h3FFFF; atk_rate = '0; dec_rate = '0;
    rel_rate = W'(TAIL_REL);
    note_on = 8'h01; expect_v(0, 0, 1, 0); step(); note_on = '0;
    expect_v(0, 'h3FFFF, 1, 0); step();
    expect_v(0, 'h3FFFF, 1, 0); step();
    note_off = 8'h01; expect_v(0, 'h3FFFF, 1, 0); step(); note_off = '0;
    lvl = 'h3FFFF; n = 0;
    while (lvl != 0 && n < 4000) begin
      lvl = rel_next(lvl, TAIL_REL); expect_v(0, lvl, lvl != 0, lvl == 0); step(); n++;
    end
    repeat (3) begin expect_v(0, 0, 0, 0); step(); end

    repeat (2) step();
    check_eq("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
